// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and default geometry for the data-RAM access controller.
//   mem_state_t  : sequencing states (IDLE, ACC_LO, ACC_HI, RESP)
//   MEM_ADDR_W   : default RAM address width
//   MEM_DATA_W   : default RAM byte width (requests/responses are 2x this)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } mem_state_t;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences one load/store request (single byte or little-endian byte pair)
// onto a byte-wide RAM with combinational read data, one byte per cycle,
// and returns a one-cycle completion pulse.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_write, req_pair     : store/load, pair/single
//   req_addr, req_wdata     : base byte address, store data ([7:0] -> addr)
//   rsp_valid, rsp_rdata    : completion pulse, last load result
//   mem_address, mem_write,
//   mem_wdata, mem_rdata    : RAM port
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_pair,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,

    output logic                  rsp_valid,
    output logic [2*DATA_W-1:0]   rsp_rdata,

    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    mem_state_t             state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [2*DATA_W-1:0]    wdata_q;
    logic [2*DATA_W-1:0]    rdata_q;
    logic                   write_q;
    logic                   pair_q;

    // Registered outputs, loaded with the value belonging to the state
    // being entered so they are glitch-free in that state.
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic                   mem_we_q;
    logic [DATA_W-1:0]      mem_wdata_q;

    // Address of the second byte of a pair; wraps at the top of the space.
    logic [ADDR_W-1:0]      addr_hi;
    assign addr_hi = addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            pair_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        pair_q      <= req_pair;
                        req_ready_q <= 1'b0;
                        mem_addr_q  <= req_addr;
                        mem_we_q    <= req_write;
                        mem_wdata_q <= req_wdata[DATA_W-1:0];
                        state_q     <= ACC_LO;
                    end
                end

                ACC_LO: begin
                    if (!write_q) begin
                        rdata_q[DATA_W-1:0] <= mem_rdata;
                        // A single-byte load returns a zero-extended byte.
                        if (!pair_q) rdata_q[2*DATA_W-1:DATA_W] <= '0;
                    end
                    if (pair_q) begin
                        mem_addr_q  <= addr_hi;
                        mem_wdata_q <= wdata_q[2*DATA_W-1:DATA_W];
                        state_q     <= ACC_HI;
                    end else begin
                        mem_addr_q  <= addr_q;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                ACC_HI: begin
                    if (!write_q) rdata_q[2*DATA_W-1:DATA_W] <= mem_rdata;
                    mem_addr_q  <= addr_q;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end

                RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end

                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    // Gate with reset so an edge that resets the block never writes the RAM,
    // even when the FSM is mid-store.
    assign mem_write   = mem_we_q & ~reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_pair;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  mem_address;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int tests = 0;
    int fails = 0;

    // Behavioural RAM driven by the DUT.
    logic [7:0] ram [256];
    bit         ram_init = 1'b0;

    // Reference: expected RAM contents and expected rsp_rdata.
    logic [7:0]  ref_mem [256];
    logic [15:0] last_rd;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_pair    (req_pair),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_address];

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37) ^ 8'h5A;
            ram_init <= 1'b1;
        end else if (mem_write) begin
            ram[mem_address] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (called #1 after a rising edge) and follow
    // it to completion, checking every RAM-side cycle against the model.
    task automatic do_req(input bit w, input bit p, input logic [7:0] a, input logic [15:0] d);
        int n;
        logic [7:0] ea;
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_pair = p; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        // Scramble the payload: only the accept-edge values may matter.
        req_valid = 1'b0; req_write = ~w; req_pair = ~p;
        req_addr = 8'($urandom); req_wdata = 16'($urandom);
        n = 0;
        while (!rsp_valid && n < 8) begin
            ea = a + 8'(n);
            check("acc_mem_write", mem_write, w);
            check("acc_mem_address", mem_address, ea);
            if (w) check("acc_mem_wdata", mem_wdata, (n == 0) ? d[7:0] : d[15:8]);
            @(posedge clk); #1;
            n++;
        end
        check("rsp_latency", n, p ? 2 : 1);
        check("rsp_valid_hi", rsp_valid, 1'b1);
        check("resp_mem_write", mem_write, 1'b0);
        if (w) begin
            ref_mem[a] = d[7:0];
            if (p) ref_mem[8'(a + 8'd1)] = d[15:8];
        end else begin
            last_rd = p ? {ref_mem[8'(a + 8'd1)], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        check("rsp_rdata", rsp_rdata, last_rd);
        @(posedge clk); #1;
        check("rsp_valid_pulse", rsp_valid, 1'b0);
        check("ready_after_rsp", req_ready, 1'b1);
    endtask

    initial begin
        int   cnt;
        int   n;
        int   bad;
        bit   accepted;
        bit   seen;
        bit   rw, rp;
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37) ^ 8'h5A;
        last_rd   = 16'h0000;
        reset     = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_pair = 1'b0;
        req_addr  = 8'h00; req_wdata = 16'h0000;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_rsp_rdata", rsp_rdata, 16'h0000);
        reset = 1'b0;

        // Single store then single load.
        do_req(1'b1, 1'b0, 8'h10, 16'h00A5);
        check("ram_10", ram[8'h10], 8'hA5);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000);
        check("load_10", rsp_rdata, 16'h00A5);

        // Pair store / load.
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF);
        check("ram_20", ram[8'h20], 8'hEF);
        check("ram_21", ram[8'h21], 8'hBE);
        do_req(1'b0, 1'b1, 8'h20, 16'h0000);
        check("load_20", rsp_rdata, 16'hBEEF);

        // Pair at the top of the address space wraps to 0x00.
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234);
        check("ram_ff", ram[8'hFF], 8'h34);
        check("ram_00", ram[8'h00], 8'h12);
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000);
        check("load_ff", rsp_rdata, 16'h1234);

        // Reset during ACC_HI of a pair store.
        req_valid = 1'b1; req_write = 1'b1; req_pair = 1'b1;
        req_addr = 8'h30; req_wdata = 16'hCAFE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_lo_addr", mem_address, 8'h30);
        check("mid_lo_we", mem_write, 1'b1);
        @(posedge clk); #1;
        check("mid_hi_addr", mem_address, 8'h31);
        check("mid_hi_we", mem_write, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_we_gated", mem_write, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[8'h30] = 8'hFE;
        last_rd = 16'h0000;
        check("mid_rsp_valid", rsp_valid, 1'b0);
        check("mid_req_ready", req_ready, 1'b1);
        check("mid_mem_address", mem_address, 8'h00);
        check("mid_rsp_rdata", rsp_rdata, 16'h0000);
        check("mid_ram_30", ram[8'h30], 8'hFE);
        check("mid_ram_31", ram[8'h31], ref_mem[8'h31]);
        @(posedge clk); #1;
        check("mid_no_rsp", rsp_valid, 1'b0);

        // Pair load of 0x20, with a store held valid (changing payload) while busy.
        check("hold_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b0; req_pair = 1'b1; req_addr = 8'h20;
        @(posedge clk); #1;
        cnt = 0; accepted = 1'b0; seen = 1'b0;
        while (!accepted && cnt < 10) begin
            req_write = 1'b1; req_pair = 1'b0;
            if (rsp_valid) begin
                check("hold_load_rdata", rsp_rdata, 16'hBEEF);
                seen = 1'b1;
            end
            if (req_ready) begin
                req_addr = 8'h40; req_wdata = 16'h0077; accepted = 1'b1;
            end else begin
                req_addr = 8'h50 + 8'(cnt); req_wdata = 16'($urandom);
            end
            @(posedge clk); #1;
            cnt++;
        end
        req_valid = 1'b0; req_addr = 8'h5F; req_wdata = 16'hFFFF;
        check("hold_accepted", accepted, 1'b1);
        check("hold_load_seen", seen, 1'b1);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        ref_mem[8'h40] = 8'h77;
        last_rd = 16'hBEEF;
        check("hold_store_rsp", rsp_valid, 1'b1);
        check("hold_store_rdata", rsp_rdata, 16'hBEEF);
        @(posedge clk); #1;
        check("hold_ram_40", ram[8'h40], 8'h77);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom);
            rp = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            do_req(rw, rp, ra, 16'($urandom));
        end

        // Whole-RAM comparison against the model.
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_image_mismatches", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
